// File: rtl/fir_decimate_if.sv
// FIFO-side handshake bundle for fir_decimate: master is the filter, slave is the FIFO pair.
interface fir_decimate_if;
    logic               in_rd_en;
    logic               in_empty;
    logic signed [31:0] in_dout;
    logic               out_wr_en;
    logic               out_full;
    logic signed [31:0] out_din;

    modport master (
        output in_rd_en,
        input  in_empty,
        input  in_dout,
        output out_wr_en,
        input  out_full,
        output out_din
    );

    modport slave (
        input  in_rd_en,
        output in_empty,
        output in_dout,
        input  out_wr_en,
        output out_full,
        input  out_din
    );
endinterface

// File: rtl/fir_decimate.sv
// Decimating FIR low-pass, single sequential MAC; FIR_DECIMATE_SATURATE_EN selects a 64-bit clamped accumulator.
// Latency: last read of a window at t -> MAC over t+1..t+TAPS -> write at t+TAPS+1.
// Backpressure: in_empty stalls filling, out_full holds the result indefinitely; reads and writes never overlap.
module fir_decimate #(
    parameter int TAPS       = 32,
    parameter int DECIMATION = 8,
    parameter int QUANT_BITS = 10,
    parameter logic signed [31:0] COEFFS [0:TAPS-1] = '{default: 32'sd1024}
) (
    input  logic          clock,
    input  logic          reset,
    fir_decimate_if.master bus
);
    localparam int CW = (DECIMATION > 1) ? $clog2(DECIMATION) : 1;
    localparam int TW = (TAPS > 1) ? $clog2(TAPS) : 1;
    localparam logic [CW-1:0] LAST_FILL = CW'(DECIMATION - 1);
    localparam logic [TW-1:0] LAST_TAP  = TW'(TAPS - 1);

    typedef enum logic [1:0] {S_FILL, S_MAC, S_OUT} state_t;

    state_t             state, state_nxt;
    logic signed [31:0] x [0:TAPS-1];
    logic [CW-1:0]      fill_cnt;
    logic [TW-1:0]      tap;
    logic signed [63:0] coef_ext, samp_ext, product;
    logic signed [31:0] result;
    logic               rd, wr;

`ifdef FIR_DECIMATE_SATURATE_EN
    localparam logic signed [63:0] MAX32 = 64'sd2147483647;
    localparam logic signed [63:0] MIN32 = -64'sd2147483648;
    logic signed [63:0] acc;

    always_comb begin
        if (acc > MAX32)
            result = 32'sh7fff_ffff;
        else if (acc < MIN32)
            result = 32'sh8000_0000;
        else
            result = acc[31:0];
    end
`else
    logic signed [31:0] acc;

    assign result = acc;
`endif

    // Full-width signed product; the arithmetic shift floors toward -inf.
    assign coef_ext = {{32{COEFFS[tap][31]}}, COEFFS[tap]};
    assign samp_ext = {{32{x[tap][31]}}, x[tap]};
    assign product  = coef_ext * samp_ext;

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            state <= S_FILL;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        rd        = 1'b0;
        wr        = 1'b0;
        case (state)
            S_FILL: begin
                rd = !bus.in_empty;
                if (rd && fill_cnt == LAST_FILL)
                    state_nxt = S_MAC;
            end
            S_MAC: begin
                if (tap == LAST_TAP)
                    state_nxt = S_OUT;
            end
            S_OUT: begin
                wr = !bus.out_full;
                if (wr)
                    state_nxt = S_FILL;
            end
            default: state_nxt = S_FILL;
        endcase
        // Outputs are quiet while reset is held, whatever state is being cleared.
        if (reset) begin
            rd = 1'b0;
            wr = 1'b0;
        end
    end

    assign bus.in_rd_en  = rd;
    assign bus.out_wr_en = wr;
    assign bus.out_din   = wr ? result : 32'sd0;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < TAPS; k++)
                x[k] <= '0;
            acc      <= '0;
            fill_cnt <= '0;
            tap      <= '0;
        end else begin
            case (state)
                S_FILL: begin
                    if (rd) begin
                        for (int k = TAPS - 1; k > 0; k--)
                            x[k] <= x[k-1];
                        x[0] <= bus.in_dout;
                        if (fill_cnt == LAST_FILL) begin
                            fill_cnt <= '0;
                            acc      <= '0;
                            tap      <= '0;
                        end else begin
                            fill_cnt <= fill_cnt + 1'b1;
                        end
                    end
                end
                S_MAC: begin
`ifdef FIR_DECIMATE_SATURATE_EN
                    acc <= acc + (product >>> QUANT_BITS);
`else
                    acc <= acc + 32'(product >>> QUANT_BITS);
`endif
                    tap <= (tap == LAST_TAP) ? '0 : tap + 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: doc/fir_decimate.md
# fir_decimate

Real-valued decimating FIR low-pass filter directly downstream of the FM demodulator: consumes the demodulated audio sample stream from a 32-bit FIFO and produces one filtered sample per DECIMATION input samples into an output FIFO. A sequential single-multiplier MAC computes each output over TAPS clock cycles. It feeds the audio de-emphasis/gain chain.

## Interface
- TAPS, 32, number of filter taps; must be greater than or equal to DECIMATION.
- DECIMATION, 8, input samples consumed per output sample; must be at least 1.
- QUANT_BITS, 10, fixed-point fraction bits used by dequantize.
- COEFFS, GLOBALS::AUDIO_LPF_COEFFS, signed 32-bit coefficient array [0:TAPS-1].
- clock  input  1  system clock
- reset  input  1  reset, asynchronous, active-high
- in_rd_en  output  1  pop request to the input FIFO
- in_empty  input  1  input FIFO empty
- in_dout  input  32  signed demodulated sample
- out_wr_en  output  1  push request to the output FIFO
- out_full  input  1  output FIFO full
- out_din  output  32  signed filtered sample

## Operation
- Shift register x[0..TAPS-1], 32-bit signed. x[0] holds the newest sample. Each accepted sample shifts x[k] into x[k+1], discards x[TAPS-1], and loads x[0].
- FSM states and transitions:
  - S_FILL: in_rd_en = !in_empty (combinational). Each read shifts the sample in and increments fill_cnt. On the DECIMATION-th read, fill_cnt clears, acc clears, and the FSM goes to S_MAC.
  - S_MAC: one tap per cycle, k = 0..TAPS-1. term = (COEFFS[k] * x[k]) is a 64-bit signed product, then arithmetic-shifted right by QUANT_BITS (floor, so -1 >>> 10 = -1). acc += term. After k = TAPS-1 the FSM goes to S_OUT. No reads occur in this state.
  - S_OUT: when !out_full, out_wr_en = 1, out_din = result, and the FSM goes to S_FILL. Otherwise the FSM holds.
- Arithmetic without saturation: the low 32 bits of each term are added into a 32-bit accumulator, which wraps modulo 2^32.
- out_din is driven as 0 whenever out_wr_en = 0.
- Reset values:
  - in_rd_en = 0, out_wr_en = 0, out_din = 0.
  - x[] all 0, acc = 0, fill_cnt = 0, tap index = 0, state S_FILL.
- Reset mid-operation (any state) discards the partial window and any pending output. The first output after reset sees zeros in the older taps.
- in_empty in S_FILL stalls without losing fill_cnt. out_full in S_OUT stalls indefinitely; out_din is not presented until the write occurs.

## Timing
- Read of the last sample of a window at cycle t puts the FSM in S_MAC at t+1.
- The MAC runs through cycle t+TAPS. out_wr_en is asserted at t+TAPS+1 if !out_full.
- Throughput with no stalls: one output per DECIMATION + TAPS + 1 cycles.
- Reads are one per cycle while in S_FILL and !in_empty. Back-to-back reads are permitted.
- At most one of in_rd_en and out_wr_en is high in any cycle.

## Configuration
- FIR_DECIMATE_SATURATE_EN defined:
  - Terms are kept at full 64-bit width (after the shift), and acc is 64-bit signed.
  - In S_OUT, result is clamped to [-2147483648, 2147483647].
- FIR_DECIMATE_SATURATE_EN undefined: the 32-bit wrapping accumulator described in Operation is used, and result = acc[31:0].
- Cycle timing is identical in both builds.

## Test plan
All tests use TAPS=32 and DECIMATION=8, with COEFFS overridden as stated.
- Impulse: COEFFS[k]=(k+1)*1024. Input 1024 followed by 39 zeros -> outputs 8192, 16384, 24576, 32768, then 0.
- DC and sign: COEFFS[k]=1024. Constant input 1024 -> 8192, 16384, 24576, 32768, 32768, ... Constant input -1 with COEFFS[k]=1 -> -8, -16, -24, -32 (floor rounding).
- Backpressure: hold out_full=1 for 20 cycles while in S_OUT -> out_wr_en stays 0 and in_rd_en stays 0. The write occurs on the cycle after release with the correct value.
- Starvation: in_empty toggles every other cycle -> outputs match the no-stall run. Exactly 8 reads occur per output.
- Saturation: COEFFS[k]=2^20, constant input 2^20. With FIR_DECIMATE_SATURATE_EN -> every output is 2147483647. Without it -> every output is 0 (2^33 and 2^35 wrap).
- Reset mid-MAC: assert reset during S_MAC of window 2 -> all outputs are 0 in the same cycle, with no write. After release, an impulse replay yields the impulse sequence exactly.
